// File: rtl/core_pkg.sv
// Shared core types and constants for the retirement stage: physical tag type,
// commit width, ROB geometry, exception vector and the retire FSM state encoding.
package core_pkg;

  localparam int ISSUE_WIDTH = 2;
  localparam int ROB_ENTRIES = 32;
  localparam int IDX_W = $clog2(ROB_ENTRIES);
  localparam int PREG_W = 6;
  localparam int ARCH_REGS = 32;
  localparam logic [4:0] XZR = 5'd31;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0100;

  typedef logic [PREG_W-1:0] preg_tag_t;
  typedef logic [IDX_W-1:0] rob_idx_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } retire_state_t;

  // ROB slot after idx, wrapping at the ROB depth even if it is not a power of two.
  function automatic rob_idx_t rob_idx_next(input rob_idx_t idx);
    return (idx == rob_idx_t'(ROB_ENTRIES - 1)) ? '0 : idx + rob_idx_t'(1);
  endfunction

endpackage

// File: rtl/retire_unit_if.sv
// Bundle between the ROB commit port / downstream consumers and the retire unit.
interface retire_unit_if;
  import core_pkg::*;

  // Handshake: the commit bundle is valid-only. The retire unit never applies
  // backpressure; every valid slot is consumed in the cycle it is presented
  // (and silently dropped while a flush/recover sequence is in progress).
  // Every output *_valid / *_en is a single-cycle pulse with no ready.
  logic [ISSUE_WIDTH-1:0]        commit_valid;
  logic [ISSUE_WIDTH-1:0]        commit_exception;
  logic [ISSUE_WIDTH-1:0]        commit_is_store;
  logic [ISSUE_WIDTH-1:0]        commit_is_branch;
  logic [ISSUE_WIDTH-1:0]        commit_branch_taken;
  logic [ISSUE_WIDTH-1:0]        commit_branch_is_call;
  logic [ISSUE_WIDTH-1:0]        commit_branch_is_return;
  logic [ISSUE_WIDTH-1:0][4:0]   commit_arch_rd;
  preg_tag_t [ISSUE_WIDTH-1:0]   commit_phys_rd;
  rob_idx_t [ISSUE_WIDTH-1:0]    commit_rob_idx;
  logic [ISSUE_WIDTH-1:0][31:0]  commit_pc;
  logic [ISSUE_WIDTH-1:0][31:0]  commit_branch_target;

  logic [ISSUE_WIDTH-1:0]        free_valid;
  preg_tag_t [ISSUE_WIDTH-1:0]   free_tag;
  logic [ISSUE_WIDTH-1:0]        store_release_valid;
  rob_idx_t [ISSUE_WIDTH-1:0]    store_release_rob_idx;
  logic [ISSUE_WIDTH-1:0]        bp_upd_valid;
  logic [ISSUE_WIDTH-1:0]        bp_upd_taken;
  logic [ISSUE_WIDTH-1:0]        bp_upd_is_call;
  logic [ISSUE_WIDTH-1:0]        bp_upd_is_return;
  logic [ISSUE_WIDTH-1:0][31:0]  bp_upd_pc;
  logic [ISSUE_WIDTH-1:0][31:0]  bp_upd_target;
  logic                          flush_en;
  rob_idx_t                      flush_ptr;
  logic                          redirect_valid;
  logic [31:0]                   redirect_pc;
  logic [31:0]                   epc;
  logic                          rat_restore_en;
  preg_tag_t [ARCH_REGS-1:0]     rat_restore_map;
  logic [63:0]                   retired_count;

  modport master (
    output commit_valid, commit_exception, commit_is_store, commit_is_branch,
           commit_branch_taken, commit_branch_is_call, commit_branch_is_return,
           commit_arch_rd, commit_phys_rd, commit_rob_idx, commit_pc, commit_branch_target,
    input  free_valid, free_tag, store_release_valid, store_release_rob_idx,
           bp_upd_valid, bp_upd_taken, bp_upd_is_call, bp_upd_is_return, bp_upd_pc,
           bp_upd_target, flush_en, flush_ptr, redirect_valid, redirect_pc, epc,
           rat_restore_en, rat_restore_map, retired_count
  );

  modport slave (
    input  commit_valid, commit_exception, commit_is_store, commit_is_branch,
           commit_branch_taken, commit_branch_is_call, commit_branch_is_return,
           commit_arch_rd, commit_phys_rd, commit_rob_idx, commit_pc, commit_branch_target,
    output free_valid, free_tag, store_release_valid, store_release_rob_idx,
           bp_upd_valid, bp_upd_taken, bp_upd_is_call, bp_upd_is_return, bp_upd_pc,
           bp_upd_target, flush_en, flush_ptr, redirect_valid, redirect_pc, epc,
           rat_restore_en, rat_restore_map, retired_count
  );

endinterface

// File: rtl/retire_rat.sv
// Retirement rename map: 32 entries, one write port per commit slot, old-tag reads
// that see earlier same-cycle writes, and the full registered image.
module retire_rat
  import core_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ISSUE_WIDTH-1:0]      we,
  input  logic [ISSUE_WIDTH-1:0][4:0] waddr,
  input  preg_tag_t [ISSUE_WIDTH-1:0] wdata,
  output preg_tag_t [ISSUE_WIDTH-1:0] old_tag,
  output preg_tag_t [ARCH_REGS-1:0]   map_image
);

  preg_tag_t [ARCH_REGS-1:0] map_q;
  preg_tag_t [ARCH_REGS-1:0] map_d;

  // A later slot's old mapping is the newest earlier-slot write to the same rd.
  always_comb begin
    for (int w = 0; w < ISSUE_WIDTH; w++) begin
      old_tag[w] = map_q[waddr[w]];
      for (int p = 0; p < w; p++) begin
        if (we[p] && (waddr[p] == waddr[w])) old_tag[w] = wdata[p];
      end
    end
  end

  always_comb begin
    map_d = map_q;
    for (int w = 0; w < ISSUE_WIDTH; w++) begin
      if (we[w]) map_d[waddr[w]] = wdata[w];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= preg_tag_t'(i);
    end else begin
      map_q <= map_d;
    end
  end

  assign map_image = map_q;

endmodule

// File: rtl/retire_unit.sv
// Two-wide retirement: updates the retirement RAT, frees superseded tags, releases
// stores, trains the predictor and sequences flush/redirect/RAT-restore on exceptions.
module retire_unit
  import core_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  retire_unit_if.slave  rif,
  output retire_state_t state
);

  retire_state_t state_q, state_d;
  logic [ISSUE_WIDTH-1:0]        free_valid_q, free_valid_d;
  preg_tag_t [ISSUE_WIDTH-1:0]   free_tag_q, free_tag_d;
  logic [ISSUE_WIDTH-1:0]        rel_valid_q, rel_valid_d;
  rob_idx_t [ISSUE_WIDTH-1:0]    rel_idx_q, rel_idx_d;
  logic [ISSUE_WIDTH-1:0]        bp_valid_q, bp_valid_d;
  logic [ISSUE_WIDTH-1:0]        bp_taken_q, bp_taken_d;
  logic [ISSUE_WIDTH-1:0]        bp_call_q, bp_call_d;
  logic [ISSUE_WIDTH-1:0]        bp_ret_q, bp_ret_d;
  logic [ISSUE_WIDTH-1:0][31:0]  bp_pc_q, bp_pc_d;
  logic [ISSUE_WIDTH-1:0][31:0]  bp_tgt_q, bp_tgt_d;
  logic                          flush_en_q, flush_en_d;
  rob_idx_t                      flush_ptr_q, flush_ptr_d;
  logic                          redirect_valid_q, redirect_valid_d;
  logic [31:0]                   redirect_pc_q, redirect_pc_d;
  logic [31:0]                   epc_q, epc_d;
  logic                          restore_en_q, restore_en_d;
  logic [63:0]                   count_q, count_d;

  logic [ISSUE_WIDTH-1:0]        slot_ok;
  logic [ISSUE_WIDTH-1:0]        slot_exc;
  logic [ISSUE_WIDTH-1:0]        rat_we;
  preg_tag_t [ISSUE_WIDTH-1:0]   rat_old;
  preg_tag_t [ARCH_REGS-1:0]     rat_image;

  // Slot qualification kept apart from the output logic so the RAT bypass
  // path (we -> old_tag) never loops back through the same block.
  always_comb begin
    logic blocked;
    blocked  = 1'b0;
    slot_ok  = '0;
    slot_exc = '0;
    rat_we   = '0;
    for (int w = 0; w < ISSUE_WIDTH; w++) begin
      if ((state_q == RUN) && rif.commit_valid[w] && !blocked) begin
        slot_ok[w]  = !rif.commit_exception[w];
        slot_exc[w] = rif.commit_exception[w];
        rat_we[w]   = !rif.commit_exception[w] && (rif.commit_arch_rd[w] != XZR);
      end
      blocked = blocked | (rif.commit_valid[w] & rif.commit_exception[w]);
    end
  end

  retire_rat u_rat (
    .clk       (clk),
    .reset     (reset),
    .we        (rat_we),
    .waddr     (rif.commit_arch_rd),
    .wdata     (rif.commit_phys_rd),
    .old_tag   (rat_old),
    .map_image (rat_image)
  );

  always_comb begin
    state_d          = state_q;
    free_valid_d     = '0;
    free_tag_d       = '0;
    rel_valid_d      = '0;
    rel_idx_d        = '0;
    bp_valid_d       = '0;
    bp_taken_d       = '0;
    bp_call_d        = '0;
    bp_ret_d         = '0;
    bp_pc_d          = '0;
    bp_tgt_d         = '0;
    flush_en_d       = 1'b0;
    flush_ptr_d      = flush_ptr_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    epc_d            = epc_q;
    restore_en_d     = 1'b0;
    count_d          = count_q;
    unique case (state_q)
      RUN: begin
        for (int w = 0; w < ISSUE_WIDTH; w++) begin
          if (slot_ok[w]) begin
            count_d = count_d + 64'd1;
            if (rat_we[w]) begin
              free_valid_d[w] = 1'b1;
              free_tag_d[w]   = rat_old[w];
            end
            if (rif.commit_is_store[w]) begin
              rel_valid_d[w] = 1'b1;
              rel_idx_d[w]   = rif.commit_rob_idx[w];
            end
            if (rif.commit_is_branch[w]) begin
              bp_valid_d[w] = 1'b1;
              bp_taken_d[w] = rif.commit_branch_taken[w];
              bp_call_d[w]  = rif.commit_branch_is_call[w];
              bp_ret_d[w]   = rif.commit_branch_is_return[w];
              bp_pc_d[w]    = rif.commit_pc[w];
              bp_tgt_d[w]   = rif.commit_branch_target[w];
            end
          end
          // At most one slot_exc bit can be set: later slots are blocked.
          if (slot_exc[w]) begin
            epc_d       = rif.commit_pc[w];
            flush_ptr_d = rob_idx_next(rif.commit_rob_idx[w]);
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_en_d       = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = EXC_VECTOR;
        state_d          = RECOVER;
      end
      RECOVER: begin
        restore_en_d = 1'b1;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= RUN;
      free_valid_q     <= '0;
      free_tag_q       <= '0;
      rel_valid_q      <= '0;
      rel_idx_q        <= '0;
      bp_valid_q       <= '0;
      bp_taken_q       <= '0;
      bp_call_q        <= '0;
      bp_ret_q         <= '0;
      bp_pc_q          <= '0;
      bp_tgt_q         <= '0;
      flush_en_q       <= 1'b0;
      flush_ptr_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      epc_q            <= '0;
      restore_en_q     <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      free_valid_q     <= free_valid_d;
      free_tag_q       <= free_tag_d;
      rel_valid_q      <= rel_valid_d;
      rel_idx_q        <= rel_idx_d;
      bp_valid_q       <= bp_valid_d;
      bp_taken_q       <= bp_taken_d;
      bp_call_q        <= bp_call_d;
      bp_ret_q         <= bp_ret_d;
      bp_pc_q          <= bp_pc_d;
      bp_tgt_q         <= bp_tgt_d;
      flush_en_q       <= flush_en_d;
      flush_ptr_q      <= flush_ptr_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      epc_q            <= epc_d;
      restore_en_q     <= restore_en_d;
      count_q          <= count_d;
    end
  end

  assign state                     = state_q;
  assign rif.free_valid            = free_valid_q;
  assign rif.free_tag              = free_tag_q;
  assign rif.store_release_valid   = rel_valid_q;
  assign rif.store_release_rob_idx = rel_idx_q;
  assign rif.bp_upd_valid          = bp_valid_q;
  assign rif.bp_upd_taken          = bp_taken_q;
  assign rif.bp_upd_is_call        = bp_call_q;
  assign rif.bp_upd_is_return      = bp_ret_q;
  assign rif.bp_upd_pc             = bp_pc_q;
  assign rif.bp_upd_target         = bp_tgt_q;
  assign rif.flush_en              = flush_en_q;
  assign rif.flush_ptr             = flush_ptr_q;
  assign rif.redirect_valid        = redirect_valid_q;
  assign rif.redirect_pc           = redirect_pc_q;
  assign rif.epc                   = epc_q;
  assign rif.rat_restore_en        = restore_en_q;
  assign rif.rat_restore_map       = rat_image;
  assign rif.retired_count         = count_q;

endmodule
